// File: rtl/box_overlay_pkg.sv
// Shared definitions for the box overlay block.
//   - FSM state encoding (IDLE/SHOW)
//   - guard-band underflow threshold for left/top coordinates
//   - default border colour
//   - box and sync bundle structs
package box_overlay_pkg;

  localparam logic        STATE_IDLE  = 1'b0;
  localparam logic        STATE_SHOW  = 1'b1;

  // Tracker coordinates can go slightly negative near the frame edge and
  // wrap to the top of the 12-bit range.
  localparam logic [11:0] UFLOW_TH    = 12'hF00;

  localparam logic [23:0] DEF_BOX_RGB = 24'hFF0000;

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
    logic [11:0] t;
    logic [11:0] b;
  } box_t;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

endpackage

// File: rtl/box_clamp.sv
// Combinational sanitiser for one axis of the tracker box.
//   lo_raw/hi_raw : raw low/high coordinate from the tracker
//   lo/hi         : clamped coordinates
//   ok            : clamped pair is ordered (lo <= hi)
// LIMIT is the active size of the axis; hi is clamped to LIMIT-1.
module box_clamp
  import box_overlay_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic [11:0] lo_raw,
  input  logic [11:0] hi_raw,
  output logic [11:0] lo,
  output logic [11:0] hi,
  output logic        ok
);

  always_comb begin
    lo = (lo_raw >= UFLOW_TH)    ? 12'd0          : lo_raw;
    hi = (hi_raw >= 12'(LIMIT))  ? 12'(LIMIT - 1) : hi_raw;
    ok = (lo <= hi);
  end

endmodule

// File: rtl/box_overlay.sv
// Draws the tracker bounding box outline onto the LCD pixel stream.
//   clk, rst_n                : pixel clock, async active-low reset
//   en                        : drawing enable (does not affect box tracking)
//   lcd_vs/hs/de, hcount/vcount, rgb_in : input stream and its counters
//   hcount_l/r, vcount_l/r    : raw box from the tracker
//   lcd_vs_o/hs_o/de_o, rgb_out : output stream, 2-cycle latency
//   box_on                    : a box is latched for drawing
// The box is latched only on a vs rise, so it never changes mid-frame. After
// the tracker stops delivering a usable box the old one is held for PERSIST
// more frames.
module box_overlay
  import box_overlay_pkg::*;
#(
  parameter int          H_ACTIVE = 1024,
  parameter int          V_ACTIVE = 768,
  parameter int          THICK    = 2,
  parameter logic [23:0] BOX_RGB  = DEF_BOX_RGB,
  parameter int          PERSIST  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lcd_vs,
  input  logic        lcd_hs,
  input  logic        lcd_de,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  input  logic [23:0] rgb_in,
  input  logic [11:0] hcount_l,
  input  logic [11:0] hcount_r,
  input  logic [11:0] vcount_l,
  input  logic [11:0] vcount_r,
  output logic        lcd_vs_o,
  output logic        lcd_hs_o,
  output logic        lcd_de_o,
  output logic [23:0] rgb_out,
  output logic        box_on
);

  // ---------------- sanitise ----------------
  box_t box_raw;
  logic ok_x, ok_y, box_ok;

  box_clamp #(.LIMIT(H_ACTIVE)) u_clamp_x (
    .lo_raw (hcount_l),
    .hi_raw (hcount_r),
    .lo     (box_raw.l),
    .hi     (box_raw.r),
    .ok     (ok_x)
  );

  box_clamp #(.LIMIT(V_ACTIVE)) u_clamp_y (
    .lo_raw (vcount_l),
    .hi_raw (vcount_r),
    .lo     (box_raw.t),
    .hi     (box_raw.b),
    .ok     (ok_y)
  );

  assign box_ok = ok_x & ok_y;

  // ---------------- frame edge + FSM ----------------
  logic [1:0] vs_hist_q, vs_hist_d;
  logic       vs_rise;
  logic       state_q, state_d;
  box_t       box_q, box_d;
  logic [3:0] pcnt_q, pcnt_d;

  assign vs_rise = (vs_hist_q == 2'b01);
  assign box_on  = (state_q == STATE_SHOW);

  always_comb begin
    vs_hist_d = {vs_hist_q[0], lcd_vs};
    state_d   = state_q;
    box_d     = box_q;
    pcnt_d    = pcnt_q;
    if (vs_rise) begin
      if (box_ok) begin
        state_d = STATE_SHOW;
        box_d   = box_raw;
        pcnt_d  = 4'(PERSIST);
      end else if (state_q == STATE_SHOW) begin
        // Hold the stale box while the persistence budget lasts.
        if (pcnt_q != 4'd0) pcnt_d  = pcnt_q - 4'd1;
        else                state_d = STATE_IDLE;
      end
    end
  end

  // ---------------- hit test (13-bit, no wrap) ----------------
  logic [12:0] h13, v13, l13, r13, t13, b13, th13;
  logic        in_box, near_edge;

  always_comb begin
    h13  = {1'b0, hcount};
    v13  = {1'b0, vcount};
    l13  = {1'b0, box_q.l};
    r13  = {1'b0, box_q.r};
    t13  = {1'b0, box_q.t};
    b13  = {1'b0, box_q.b};
    th13 = 13'(THICK);
    in_box    = (h13 >= l13) && (h13 <= r13) && (v13 >= t13) && (v13 <= b13);
    near_edge = (h13 < l13 + th13) || (h13 + th13 > r13) ||
                (v13 < t13 + th13) || (v13 + th13 > b13);
  end

  // ---------------- 2-stage pipeline ----------------
  logic             draw_q, draw_d;
  logic [23:0]      rgb1_q, rgb1_d;
  logic [23:0]      rgb_out_q, rgb_out_d;
  sync_t            sync_in;
  sync_t [2:1]      sync_pipe_q, sync_pipe_d;

  assign sync_in = {lcd_vs, lcd_hs, lcd_de};

  always_comb begin
    draw_d      = en & box_on & lcd_de & in_box & near_edge;
    rgb1_d      = rgb_in;
    rgb_out_d   = draw_q ? BOX_RGB : rgb1_q;
    sync_pipe_d = {sync_pipe_q[1], sync_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_hist_q   <= 2'b00;
      state_q     <= STATE_IDLE;
      box_q       <= '0;
      pcnt_q      <= 4'd0;
      draw_q      <= 1'b0;
      rgb1_q      <= 24'd0;
      rgb_out_q   <= 24'd0;
      sync_pipe_q <= '0;
    end else begin
      vs_hist_q   <= vs_hist_d;
      state_q     <= state_d;
      box_q       <= box_d;
      pcnt_q      <= pcnt_d;
      draw_q      <= draw_d;
      rgb1_q      <= rgb1_d;
      rgb_out_q   <= rgb_out_d;
      sync_pipe_q <= sync_pipe_d;
    end
  end

  assign rgb_out  = rgb_out_q;
  assign lcd_vs_o = sync_pipe_q[2].vs;
  assign lcd_hs_o = sync_pipe_q[2].hs;
  assign lcd_de_o = sync_pipe_q[2].de;

endmodule

// File: tb/tb_box_overlay.sv
// Self-checking bench for box_overlay: directed scenarios plus random frames,
// compared against a frame-level reference model of the box behaviour.
module tb_box_overlay;

  localparam int          H    = 1024;
  localparam int          V    = 768;
  localparam int          TH   = 2;
  localparam int          PERS = 3;
  localparam logic [23:0] BOXC = 24'hFF0000;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic        lcd_vs = 1'b0, lcd_hs = 1'b0, lcd_de = 1'b0;
  logic [11:0] hcount = '0, vcount = '0;
  logic [11:0] hl = '0, hr = '0, vl = '0, vr = '0;
  logic [23:0] rgb_in = '0;
  logic        vs_o, hs_o, de_o, box_on;
  logic [23:0] rgb_out;

  int total = 0, bad = 0;

  typedef struct { logic [23:0] rgb; logic vs, hs, de; } exp_t;
  exp_t q[$];

  // reference model: shown box and how many consecutive unusable frames seen
  bit shown = 0;
  int miss  = 0;
  int ml = 0, mr = 0, mt = 0, mb = 0;

  box_overlay dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .lcd_vs(lcd_vs), .lcd_hs(lcd_hs), .lcd_de(lcd_de),
    .hcount(hcount), .vcount(vcount), .rgb_in(rgb_in),
    .hcount_l(hl), .hcount_r(hr), .vcount_l(vl), .vcount_r(vr),
    .lcd_vs_o(vs_o), .lcd_hs_o(hs_o), .lcd_de_o(de_o),
    .rgb_out(rgb_out), .box_on(box_on)
  );

  always #5 clk = ~clk;

  function automatic bit border(int h, int v);
    if (!(h >= ml && h <= mr && v >= mt && v <= mb)) return 0;
    return (h - ml < TH) || (mr - h < TH) || (v - mt < TH) || (mb - v < TH);
  endfunction

  task automatic chk(input string tag, input logic [23:0] act, input logic [23:0] exp);
    total++;
    assert (act === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // One clock: record what the current inputs must produce 2 cycles later.
  task automatic tick(input string tag);
    exp_t e;
    e.rgb = (en && shown && lcd_de && border(int'(hcount), int'(vcount))) ? BOXC : rgb_in;
    e.vs  = lcd_vs; e.hs = lcd_hs; e.de = lcd_de;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk({tag, ".rgb"}, rgb_out, e.rgb);
      chk({tag, ".vs"}, {23'd0, vs_o}, {23'd0, e.vs});
      chk({tag, ".hs"}, {23'd0, hs_o}, {23'd0, e.hs});
      chk({tag, ".de"}, {23'd0, de_o}, {23'd0, e.de});
    end
    @(negedge clk);
  endtask

  task automatic pix(input int h, input int v, input string tag);
    hcount = 12'(h); vcount = 12'(v);
    lcd_de = 1'b1; lcd_hs = 1'($urandom); rgb_in = 24'($urandom);
    tick(tag);
  endtask

  task automatic set_box(input logic [11:0] l, input logic [11:0] r,
                         input logic [11:0] t, input logic [11:0] b);
    hl = l; hr = r; vl = t; vr = b;
  endtask

  task automatic model_rise();
    int l, r, t, b;
    l = (int'(hl) >= 'hF00) ? 0 : int'(hl);
    t = (int'(vl) >= 'hF00) ? 0 : int'(vl);
    r = (int'(hr) >= H) ? H - 1 : int'(hr);
    b = (int'(vr) >= V) ? V - 1 : int'(vr);
    if (l <= r && t <= b) begin
      shown = 1; miss = 0; ml = l; mr = r; mt = t; mb = b;
    end else if (shown) begin
      if (miss >= PERS) shown = 0;
      else miss++;
    end
  endtask

  task automatic vsync(input string tag);
    model_rise();
    lcd_de = 1'b0; lcd_vs = 1'b1;
    repeat (3) tick({tag, ".vs_hi"});
    lcd_vs = 1'b0;
    repeat (2) tick({tag, ".vs_lo"});
    chk({tag, ".box_on"}, {23'd0, box_on}, {23'd0, shown});
  endtask

  // Random pixels around the model box (or anywhere when no box is shown).
  task automatic rand_pix(input int n, input string tag);
    int lo_h, hi_h, lo_v, hi_v;
    lo_h = shown ? ((ml > 3) ? ml - 3 : 0) : 0;
    hi_h = shown ? mr + 3 : H - 1;
    lo_v = shown ? ((mt > 3) ? mt - 3 : 0) : 0;
    hi_v = shown ? mb + 3 : V - 1;
    for (int i = 0; i < n; i++)
      pix(int'($urandom_range(hi_h, lo_h)), int'($urandom_range(hi_v, lo_v)), tag);
  endtask

  initial begin
    // ---- reset state ----
    @(negedge clk); @(negedge clk);
    chk("rst.rgb", rgb_out, 24'd0);
    chk("rst.vs", {23'd0, vs_o}, 24'd0);
    chk("rst.de", {23'd0, de_o}, 24'd0);
    chk("rst.box_on", {23'd0, box_on}, 24'd0);

    // ---- out of reset mid-frame: passthrough until vs rise ----
    en = 1'b1;
    set_box(12'd100, 12'd200, 12'd50, 12'd80);
    rst_n = 1'b1;
    pix(100, 50, "pre_rise"); pix(150, 50, "pre_rise"); pix(200, 80, "pre_rise");
    chk("pre_rise.box_on", {23'd0, box_on}, 24'd0);

    // ---- basic box ----
    vsync("basic");
    pix(100, 50, "basic.tl"); pix(101, 51, "basic.in1"); pix(200, 80, "basic.br");
    pix(102, 52, "basic.inner"); pix(99, 50, "basic.left_out");
    rand_pix(150, "basic.rand");
    for (int h = 95; h < 110; h++) pix(h, 52, "basic.row");
    blank(3);

    // ---- clamping ----
    set_box(12'hFFD, 12'd50, 12'd700, 12'd900);
    vsync("clamp");
    pix(0, 767, "clamp.c0l767"); pix(0, 720, "clamp.col0"); pix(25, 767, "clamp.l767");
    pix(25, 740, "clamp.inner");
    rand_pix(60, "clamp.rand");

    // ---- persistence ----
    set_box(12'd10, 12'd40, 12'd10, 12'd40);
    vsync("pers.valid");
    set_box(12'd300, 12'd100, 12'd10, 12'd40);
    for (int f = 0; f < 4; f++) begin
      vsync("pers.inv");
      pix(10, 10, "pers.px"); pix(40, 25, "pers.px"); pix(25, 25, "pers.px");
      rand_pix(10, "pers.rand");
    end

    // ---- mid-frame change is ignored ----
    set_box(12'd300, 12'd340, 12'd300, 12'd330);
    vsync("mid.a");
    rand_pix(20, "mid.a");
    set_box(12'd500, 12'd520, 12'd100, 12'd110);
    pix(300, 310, "mid.old_edge"); pix(500, 100, "mid.new_edge");
    rand_pix(20, "mid.still_a");
    vsync("mid.b");
    pix(500, 100, "mid.b_edge"); pix(300, 310, "mid.a_gone");
    rand_pix(20, "mid.b");

    // ---- en gating ----
    en = 1'b0;
    rand_pix(30, "en0");
    chk("en0.box_on", {23'd0, box_on}, 24'd1);
    for (int h = 498; h < 515; h++) begin
      if (h == 503) en = 1'b1;
      pix(h, 105, "en.rise_midline");
    end
    for (int h = 498; h < 512; h++) pix(h, 100, "en.top");

    // ---- random frames ----
    for (int f = 0; f < 6; f++) begin
      logic [11:0] a, b, c, d;
      a = 12'($urandom_range(1000, 0)); b = 12'($urandom_range(1100, 0));
      c = 12'($urandom_range(760, 0));  d = 12'($urandom_range(850, 0));
      if ($urandom_range(3, 0) == 0) a = 12'($urandom_range(12'hFFF, 12'hF00));
      if ($urandom_range(3, 0) == 0) c = 12'($urandom_range(12'hFFF, 12'hF00));
      en = 1'($urandom_range(3, 0) != 0);
      set_box(a, b, c, d);
      vsync("rnd");
      rand_pix(40, "rnd.px");
      if (shown) for (int h = ml; h <= ml + 6; h++) pix(h, mt + 1, "rnd.row");
    end

    // ---- async reset mid-frame in SHOW ----
    en = 1'b1;
    set_box(12'd20, 12'd60, 12'd20, 12'd60);
    vsync("rst2.pre");
    rand_pix(10, "rst2.pre");
    #2 rst_n = 1'b0;
    #1;
    chk("rst2.rgb", rgb_out, 24'd0);
    chk("rst2.de", {23'd0, de_o}, 24'd0);
    chk("rst2.hs", {23'd0, hs_o}, 24'd0);
    chk("rst2.box_on", {23'd0, box_on}, 24'd0);
    shown = 0; miss = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pix(20, 20, "rst2.pass"); pix(60, 60, "rst2.pass"); pix(40, 20, "rst2.pass");
    chk("rst2.box_on_idle", {23'd0, box_on}, 24'd0);
    vsync("rst2.post");
    pix(20, 20, "rst2.drawn"); pix(40, 40, "rst2.inner");
    blank(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic blank(input int n);
    lcd_de = 1'b0;
    for (int i = 0; i < n; i++) begin
      rgb_in = 24'($urandom);
      tick("blank");
    end
  endtask

endmodule
